// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the burst master.
//   CTI_*   : cycle type identifier encodings driven on wb_cti_i.
//   state_e : burst-master FSM state encoding.
package wb_pkg;

    localparam int unsigned CTI_WIDTH = 3;

    localparam logic [CTI_WIDTH-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_WIDTH-1:0] CTI_INCR    = 3'b010;
    localparam logic [CTI_WIDTH-1:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master (1..16 beats, read or write).
// Optional feature macro: WB_BURST_MASTER_TIMEOUT_EN enables an ack watchdog
// that aborts a burst after TIMEOUT_CYCLES strobed cycles without an ack.
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (accepted only in IDLE)
//   cmd_we, cmd_addr, cmd_len     direction, start byte address, beats-1
//   wr_data/wr_valid/wr_ready     write-data stream (consumed on write ack)
//   rd_data/rd_valid              read-data stream, no backpressure
//   done, err                     one-cycle pulses: burst end / timeout abort
//   wb_*_i / wb_*_o               Wishbone master side (slave-named signals)
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 26,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [3:0]              cmd_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    done,
    output logic                    err,
    output logic                    wb_cyc_i,
    output logic                    wb_stb_i,
    output logic                    wb_we_i,
    output logic [ADDR_WIDTH-1:0]   wb_addr_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [CTI_WIDTH-1:0]    wb_cti_i,
    input  logic                    wb_ack_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_o
);

    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;

    state_e                  state;
    state_e                  state_nxt;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              len_q;
    logic [3:0]              beat_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;
    logic                    done_q;
    logic                    accept_c;
    logic                    beat_c;
    logic                    last_c;
    logic                    timeout_c;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state and bus-side decode
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_dat_i  = '0;
        wb_sel_i  = '0;
        wb_cti_i  = CTI_CLASSIC;
        accept_c  = 1'b0;
        beat_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                wb_cyc_i = 1'b1;
                wb_we_i  = we_q;
                // Writes only strobe when a data word is actually available.
                wb_stb_i = !we_q || wr_valid;
                wb_dat_i = we_q ? wr_data : '0;
                wb_sel_i = '1;
                last_c   = (beat_q == len_q);
                if (len_q == 4'd0) wb_cti_i = CTI_CLASSIC;
                else if (last_c)   wb_cti_i = CTI_END;
                else               wb_cti_i = CTI_INCR;
                beat_c = wb_stb_i && wb_ack_o;
                if (beat_c && last_c) state_nxt = ST_DONE;
                else if (timeout_c)   state_nxt = ST_IDLE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_ready  = wb_we_i && wb_stb_i && wb_ack_o;
    assign wb_addr_i = addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;

    // Burst context, address walker and read-data capture
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= beat_c && !we_q;
            done_q     <= beat_c && last_c;
            if (accept_c) begin
                we_q   <= cmd_we;
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                beat_q <= '0;
            end else if (beat_c) begin
                // Natural overflow gives the modulo-2^ADDR_WIDTH wrap.
                addr_q <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
                beat_q <= beat_q + 4'd1;
            end
            if (beat_c && !we_q) rd_data_q <= wb_dat_o;
        end
    end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    // Fires on the strobed cycle that would bring the idle count to the limit.
    assign timeout_c = (state == ST_XFER) && wb_stb_i && !wb_ack_o &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err       = err_q;

    // Ack watchdog: counts strobed cycles since the last ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_c;
            if (accept_c || beat_c)               tmo_q <= '0;
            else if (state == ST_XFER && wb_stb_i) tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_c      = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: a beat-list model plus per-cycle
// compare process, and literal checks on logged bus activity.
module tb_wb_burst_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, done, err;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [2:0]    wb_cti_i;
    logic          wb_ack_o;
    logic [DW-1:0] wb_dat_o;

    always #5 clk = ~clk;

    wb_burst_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done),
        .err      (err),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_addr_i(wb_addr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_cti_i (wb_cti_i),
        .wb_ack_o (wb_ack_o),
        .wb_dat_o (wb_dat_o)
    );

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ 32'(a);
    endfunction

    // Slave model: acks after slave_wait strobed cycles; optional stray ack.
    logic        slave_on;
    logic        spurious_ack;
    int unsigned slave_wait;
    int unsigned wait_cnt = 0;

    assign wb_ack_o = spurious_ack | (slave_on & wb_stb_i & (wait_cnt >= slave_wait));
    assign wb_dat_o = rd_word(wb_addr_i);

    always @(posedge clk) begin
        if (!wb_cyc_i || (wb_stb_i && wb_ack_o)) wait_cnt <= 0;
        else if (wb_stb_i)                       wait_cnt <= wait_cnt + 1;
    end

    // Scoreboard / counters
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic          we;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] wdat[16];
    logic [AW-1:0] log_addr[$];
    logic [2:0]    log_cti[$];
    logic [DW-1:0] last_rd;
    int            wr_ready_cnt, done_cnt, err_cnt, rdv_cnt, stb_cnt;

    // Expected beat list from a command: addresses step by 4 bytes and wrap.
    task automatic plan(input logic we, input logic [AW-1:0] addr, input int len);
        beat_t b;
        for (int i = 0; i <= len; i++) begin
            b.addr = addr + AW'(i * 4);
            b.cti  = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
            b.we   = we;
            b.data = we ? wdat[i] : rd_word(b.addr);
            b.last = (i == len);
            exp_q.push_back(b);
        end
    endtask

    logic          exp_rdv  = 1'b0;
    logic [DW-1:0] exp_rdd  = '0;
    logic          exp_done = 1'b0;

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic          nxt_rdv;
        logic [DW-1:0] nxt_rdd;
        logic          nxt_done;
        beat_t         b;
        nxt_rdv  = 1'b0;
        nxt_rdd  = '0;
        nxt_done = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'(exp_rdv));
        if (exp_rdv) chk("rd_data", rd_data, exp_rdd);
        chk("done", 32'(done), 32'(exp_done));
`ifndef WB_BURST_MASTER_TIMEOUT_EN
        chk("err", 32'(err), 32'd0);
`endif
        if (wb_cyc_i) begin
            chk("stb_rule", 32'(wb_stb_i), 32'((!wb_we_i) || wr_valid));
            chk("sel", 32'(wb_sel_i), 32'hF);
        end
        if (wb_stb_i && wb_ack_o) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'd1, 32'd0);
            end else begin
                b = exp_q.pop_front();
                chk("beat_addr", 32'(wb_addr_i), 32'(b.addr));
                chk("beat_cti", 32'(wb_cti_i), 32'(b.cti));
                chk("beat_we", 32'(wb_we_i), 32'(b.we));
                if (b.we) chk("beat_wdata", wb_dat_i, b.data);
                log_addr.push_back(wb_addr_i);
                log_cti.push_back(wb_cti_i);
                nxt_rdv  = !b.we;
                nxt_rdd  = b.data;
                nxt_done = b.last;
            end
        end
        if (wr_ready) wr_ready_cnt++;
        if (done)     done_cnt++;
        if (err)      err_cnt++;
        if (wb_stb_i) stb_cnt++;
        if (rd_valid) begin
            rdv_cnt++;
            last_rd = rd_data;
        end
        if (rst || err) begin
            exp_q.delete();
            nxt_rdv  = 1'b0;
            nxt_done = 1'b0;
        end
        exp_rdv  = nxt_rdv;
        exp_rdd  = nxt_rdd;
        exp_done = nxt_done;
    end

    task automatic clear_logs();
        log_addr.delete();
        log_cti.delete();
        wr_ready_cnt = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        rdv_cnt      = 0;
        stb_cnt      = 0;
    endtask

    // Offer one command from IDLE; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [3:0] len);
        plan(we, addr, int'(len));
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        bit fin;
        fin = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            @(negedge clk);
            if (done || err) fin = 1;
        end
        if (!fin) chk("end_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    // Feed write data; stall_beat gets stall_len cycles of wr_valid low first.
    task automatic run_write(input int len, input int stall_beat, input int stall_len);
        int idx;
        int stall_left;
        bit fin;
        idx        = 0;
        stall_left = (stall_beat == 0) ? stall_len : 0;
        fin        = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (idx <= len && stall_left == 0) begin
                wr_valid     = 1'b1;
                wr_data      = wdat[idx];
                spurious_ack = 1'b0;
                cmd_valid    = 1'b0;
            end else begin
                wr_valid     = 1'b0;
                spurious_ack = (stall_left > 0);
                cmd_valid    = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end
            @(negedge clk);
            if (cmd_valid) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (wr_ready) begin
                idx++;
                if (idx == stall_beat) stall_left = stall_len;
            end
            if (done) fin = 1;
            @(posedge clk); #1;
        end
        wr_valid     = 1'b0;
        spurious_ack = 1'b0;
        cmd_valid    = 1'b0;
        if (!fin) chk("write_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_we       = 1'b0;
        cmd_addr     = '0;
        cmd_len      = '0;
        wr_data      = '0;
        wr_valid     = 1'b0;
        slave_on     = 1'b1;
        spurious_ack = 1'b0;
        slave_wait   = 0;
        for (int i = 0; i < 16; i++) wdat[i] = '0;
        clear_logs();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc_i), 32'd0);
        chk("rst_stb", 32'(wb_stb_i), 32'd0);
        chk("rst_we", 32'(wb_we_i), 32'd0);
        chk("rst_addr", 32'(wb_addr_i), 32'd0);
        chk("rst_dat", wb_dat_i, 32'd0);
        chk("rst_cti", 32'(wb_cti_i), 32'd0);
        chk("rst_sel", 32'(wb_sel_i), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read, slave acks one cycle after strobe
        clear_logs();
        slave_wait = 1;
        issue(1'b0, 26'h100, 4'd0);
        wait_end(50);
        chk("r1_beats", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("r1_addr", 32'(log_addr[0]), 32'h100);
            chk("r1_cti", 32'(log_cti[0]), 32'd0);
        end
        chk("r1_rdv_cnt", 32'(rdv_cnt), 32'd1);
        chk("r1_rd_data", last_rd, 32'hC0DE_0100);
        chk("r1_done_cnt", 32'(done_cnt), 32'd1);
        chk("r1_left", 32'(exp_q.size()), 32'd0);

        // 4-beat write, zero-wait slave
        clear_logs();
        slave_wait = 0;
        for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
        issue(1'b1, 26'h200, 4'd3);
        run_write(3, -1, 0);
        @(posedge clk); #1;
        chk("w4_beats", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            chk("w4_addr3", 32'(log_addr[3]), 32'h20C);
            chk("w4_cti0", 32'(log_cti[0]), 32'h2);
            chk("w4_cti3", 32'(log_cti[3]), 32'h7);
        end
        chk("w4_wr_ready_cnt", 32'(wr_ready_cnt), 32'd4);
        chk("w4_done_cnt", 32'(done_cnt), 32'd1);

        // Write with a 3-cycle data stall on beat 2, stray acks and a busy command
        clear_logs();
        for (int i = 0; i < 4; i++) wdat[i] = 32'hAB00_0010 + 32'(i);
        issue(1'b1, 26'h300, 4'd3);
        run_write(3, 1, 3);
        @(posedge clk); #1;
        chk("ws_beats", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) chk("ws_addr1", 32'(log_addr[1]), 32'h304);
        chk("ws_wr_ready_cnt", 32'(wr_ready_cnt), 32'd4);
        chk("ws_done_cnt", 32'(done_cnt), 32'd1);
        chk("ws_left", 32'(exp_q.size()), 32'd0);

        // Address wrap at the top of the 26-bit space
        clear_logs();
        issue(1'b0, 26'h3FF_FFFC, 4'd1);
        wait_end(50);
        chk("wrap_beats", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) chk("wrap_addr1", 32'(log_addr[1]), 32'h0);
        chk("wrap_rdv_cnt", 32'(rdv_cnt), 32'd2);

        // Reset during beat 3 of an 8-beat read
        clear_logs();
        issue(1'b0, 26'h400, 4'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_cyc", 32'(wb_cyc_i), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_beats", 32'(log_addr.size()), 32'd3);
        chk("mid_rst_done_cnt", 32'(done_cnt), 32'd0);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
        // Watchdog: slave never acks
        clear_logs();
        slave_on = 1'b0;
        issue(1'b0, 26'h500, 4'd0);
        wait_end(50);
        @(posedge clk); #1;
        chk("tmo_stb_cycles", 32'(stb_cnt), 32'd8);
        chk("tmo_err_cnt", 32'(err_cnt), 32'd1);
        chk("tmo_done_cnt", 32'(done_cnt), 32'd0);
        chk("tmo_cyc", 32'(wb_cyc_i), 32'd0);
        slave_on = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, Wishbone byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, ack watchdog limit, used only under WB_BURST_MASTER_TIMEOUT_EN.
REQ-004 SHALL have one clock and a synchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  reset.
REQ-005 SHALL have cmd_valid  in  1  command offered.
REQ-006 SHALL have cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have cmd_addr  in  ADDR_WIDTH  start byte address, word aligned.
REQ-009 SHALL have cmd_len  in  4  beats minus one (1..16 beats).
REQ-010 SHALL have wr_data  in  DATA_WIDTH  and  wr_valid  in  1: write-data stream; wr_ready  out  1: beat consumed.
REQ-011 SHALL have rd_data  out  DATA_WIDTH  and  rd_valid  out  1: read-data stream, no backpressure.
REQ-012 SHALL have done  out  1  one-cycle pulse at burst end; err  out  1  one-cycle pulse at timeout abort.
REQ-013 SHALL drive the slave-named Wishbone signals as master: wb_cyc_i, wb_stb_i, wb_we_i out 1; wb_addr_i out ADDR_WIDTH; wb_dat_i out DATA_WIDTH; wb_sel_i out DATA_WIDTH/8; wb_cti_i out 3; wb_ack_o in 1; wb_dat_o in DATA_WIDTH.

Function
REQ-014 SHALL implement FSM states IDLE, XFER, DONE.
REQ-015 IDLE: cmd_ready=1; on cmd_valid latch we/addr/len, beat counter=0, go XFER next cycle.
REQ-016 XFER: wb_cyc_i=1 every cycle; wb_stb_i=1 for reads always, for writes only while wr_valid=1 (wb_dat_i=wr_data combinationally).
REQ-017 A beat completes on wb_stb_i & wb_ack_o; wr_ready = wb_we_i & wb_stb_i & wb_ack_o.
REQ-018 Read beat: rd_data registered from wb_dat_o, rd_valid pulses one cycle after the ack cycle.
REQ-019 Per completed beat, wb_addr_i SHALL increment by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
REQ-020 wb_cti_i SHALL be 3'b000 when cmd_len=0; otherwise 3'b010 on non-final beats and 3'b111 on the final beat; wb_sel_i all ones.
REQ-021 On final-beat ack go DONE; DONE drops cyc/stb, pulses done, returns to IDLE (minimum 1 idle cycle between bursts).
REQ-022 cmd_valid while not IDLE SHALL be ignored (cmd_ready=0).
REQ-023 wb_ack_o while wb_stb_i=0 SHALL be ignored.

Reset
REQ-024 On wb_rst_i (sampled at clock edge) FSM SHALL enter IDLE in the next cycle, even mid-burst, abandoning it without done/err.
REQ-025 Reset values: cyc/stb/we=0, addr=0, dat=0, cti=0, sel=0, cmd_ready=1 after reset, wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0.

Configuration
REQ-026 With WB_BURST_MASTER_TIMEOUT_EN defined, a counter SHALL clear on each ack and count XFER cycles with stb=1; reaching TIMEOUT_CYCLES SHALL drop cyc/stb next cycle, pulse err (no done), return to IDLE.
REQ-027 Without WB_BURST_MASTER_TIMEOUT_EN, no counter exists, err is tied 0, and XFER waits indefinitely for ack.

Structure
REQ-028 Shared package wb_pkg SHALL hold the CTI constants (CLASSIC=000, INCR=010, END=111) and the FSM state enum type.
REQ-029 No sub-module; single module with one FSM and datapath registers.

Verification
REQ-030 Single read: cmd_addr=0x100, len=0, slave acks 1 cycle after stb -> cti=000, addr=0x100, rd_valid once with slave data, done pulse.
REQ-031 4-beat write, addr=0x200, data 1..4, zero-wait slave -> addrs 0x200/204/208/20C, cti 010,010,010,111, wr_ready 4 pulses, done.
REQ-032 Write with wr_valid low on beat 2 for 3 cycles -> stb low those cycles, addr held, no extra beat.
REQ-033 Read burst len=1 from addr 0x3FFFFFC (ADDR_WIDTH=26) -> second beat addr 0x0000000.
REQ-034 Reset asserted on beat 3 of 8 -> next cycle cyc=0, cmd_ready=1, no done.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 stb cycles, err pulses once, done stays 0.
